// File: rtl/core_exec_unit_mc.sv
// -----------------------------------------------------------------------------
// core_exec_unit_mc
//
// Multi-cycle execution unit for the RV32I pipeline. It sits between
// decode/register-read and writeback. An operation is accepted on an issue
// handshake. ALU operations produce their result on the next cycle. Loads and
// stores go out over a request/grant/response data-memory port, so memory
// latency can vary. The result is held until writeback accepts it.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   issue_valid_i     an operation is presented
//   issue_ready_o     unit is idle; accept happens on valid && ready
//   alu_op_i          ADD SUB SLL SLT SLTU XOR SRL SRA OR AND (0..9)
//   lis_op_i          [3] store, [2] unsigned load, [1:0] size b/h/w/illegal
//   is_loadstore_i    memory operation (address = s1 + s2)
//   s1_i, s2_i        operands (s2 is the immediate for memory operations)
//   rs2_i             store data
//   res_valid_o/res_ready_i   result handshake (backpressure from writeback)
//   res_data_o        ALU result or extended load data (0 for stores/errors)
//   res_wb_o          result must be written back (ALU ops and loads)
//   res_err_o         misaligned access; no memory transaction was issued
//   mem_req_o/mem_gnt_i       request handshake
//   mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o   request attributes
//   mem_rvalid_i, mem_rdata_i one response (read data or write ack) per grant
//
// Assumes ADDR_WIDTH <= XLEN. A size-2 access covers the full XLEN word.
// -----------------------------------------------------------------------------
module core_exec_unit_mc #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic [3:0]            lis_op_i,
  input  logic                  is_loadstore_i,
  input  logic [XLEN-1:0]       s1_i,
  input  logic [XLEN-1:0]       s2_i,
  input  logic [XLEN-1:0]       rs2_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [XLEN-1:0]       res_data_o,
  output logic                  res_wb_o,
  output logic                  res_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [XLEN/8-1:0]     mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i
);

  localparam int BE_W    = XLEN / 8;
  localparam int OFF_W   = $clog2(BE_W);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHAMT_W-1:0] shamt;
    shamt = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  alu_eval = a + b;
      OP_SUB:  alu_eval = a - b;
      OP_SLL:  alu_eval = a << shamt;
      OP_SLT:  alu_eval = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_eval = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_eval = a ^ b;
      OP_SRL:  alu_eval = a >> shamt;
      OP_SRA:  alu_eval = $signed(a) >>> shamt;
      OP_OR:   alu_eval = a | b;
      OP_AND:  alu_eval = a & b;
      default: alu_eval = '0;
    endcase
  endfunction

  // Size 3 has no legal encoding, so it always traps.
  function automatic logic misaligned(input logic [1:0]       size,
                                      input logic [OFF_W-1:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [3:0]        lis_op_q, lis_op_d;
  logic              is_ls_q, is_ls_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   s1_q, s1_d;
  logic [XLEN-1:0]   s2_q, s2_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  // The alignment decision is needed in the accept cycle to choose the next
  // state. The low address bits depend only on the low operand bits.
  logic [OFF_W-1:0]  issue_off;
  logic              issue_mis;

  always_comb begin
    issue_off = s1_i[OFF_W-1:0] + s2_i[OFF_W-1:0];
    issue_mis = is_loadstore_i && misaligned(lis_op_i[1:0], issue_off);
  end

  // Datapath derived from the registered operation
  logic [XLEN-1:0]       addr_sum;
  logic [OFF_W-1:0]      off;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [XLEN-1:0]       alu_res;
  logic [BE_W-1:0]       st_be;
  logic [XLEN-1:0]       st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [XLEN-1:0]       load_ext;

  always_comb begin
    addr_sum  = s1_q + s2_q;
    off       = addr_sum[OFF_W-1:0];
    word_addr = {addr_sum[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    alu_res   = alu_eval(alu_op_q, s1_q, s2_q);

    // Store lane steering: the data is replicated across every lane, so the
    // byte enables alone choose which bytes are written.
    case (lis_op_q[1:0])
      2'd0: begin
        st_be    = BE_W'(1) << off;
        st_wdata = {BE_W{rs2_q[7:0]}};
      end
      2'd1: begin
        st_be    = BE_W'(3) << {off[OFF_W-1:1], 1'b0};
        st_wdata = {(BE_W/2){rs2_q[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = rs2_q;
      end
    endcase

    // Load lane selection. The half base ignores off[0] because aligned halves
    // always have it clear. This keeps the select inside the word.
    ld_byte = rdata_q[{off, 3'b000} +: 8];
    ld_half = rdata_q[{off[OFF_W-1:1], 1'b0, 3'b000} +: 16];
    case (lis_op_q[1:0])
      2'd0:    load_ext = lis_op_q[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                      : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = lis_op_q[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                      : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: load_ext = rdata_q;
    endcase
  end

  // Operands are captured only on accept and held for the whole operation.
  // Read data is captured only in WAIT, so stray responses are ignored.
  always_comb begin
    alu_op_d = alu_op_q;
    lis_op_d = lis_op_q;
    is_ls_d  = is_ls_q;
    err_d    = err_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    rs2_d    = rs2_q;
    rdata_d  = rdata_q;
    if (state_q == IDLE && issue_valid_i) begin
      alu_op_d = alu_op_i;
      lis_op_d = lis_op_i;
      is_ls_d  = is_loadstore_i;
      err_d    = issue_mis;
      s1_d     = s1_i;
      s2_d     = s2_i;
      rs2_d    = rs2_i;
    end
    if (state_q == WAIT && mem_rvalid_i) begin
      rdata_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q <= '0;
      lis_op_q <= '0;
      is_ls_q  <= 1'b0;
      err_q    <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      rs2_q    <= '0;
      rdata_q  <= '0;
    end else begin
      alu_op_q <= alu_op_d;
      lis_op_q <= lis_op_d;
      is_ls_q  <= is_ls_d;
      err_q    <= err_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rs2_q    <= rs2_d;
      rdata_q  <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All outputs are decoded from the state. An asynchronous reset therefore
  // forces them to their idle values straight away. The memory attributes
  // come from registered operands, so they stay stable while a grant is stalled.
  always_comb begin
    state_d       = state_q;
    issue_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    res_data_o    = '0;
    res_wb_o      = 1'b0;
    res_err_o     = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    unique case (state_q)
      IDLE: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i) begin
          state_d = (is_loadstore_i && !issue_mis) ? REQ : RESP;
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = lis_op_q[3];
        // Loads fetch the whole word. The lane is picked out on return.
        mem_be_o    = lis_op_q[3] ? st_be : '1;
        mem_addr_o  = word_addr;
        mem_wdata_o = lis_op_q[3] ? st_wdata : '0;
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A store also waits here for its write acknowledge.
        if (mem_rvalid_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        res_valid_o = 1'b1;
        if (err_q) begin
          res_err_o = 1'b1;
        end else if (!is_ls_q) begin
          res_wb_o   = 1'b1;
          res_data_o = alu_res;
        end else if (!lis_op_q[3]) begin
          res_wb_o   = 1'b1;
          res_data_o = load_ext;
        end
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_exec_unit_mc.sv
module tb_core_exec_unit_mc;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [3:0]      alu_op = '0;
  logic [3:0]      lis_op = '0;
  logic            is_ls = 1'b0;
  logic [XLEN-1:0] s1 = '0, s2 = '0, rs2 = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [XLEN-1:0] res_data;
  logic            res_wb, res_err;
  logic            mem_req;
  logic            mem_gnt = 1'b0;
  logic            mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  core_exec_unit_mc #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .alu_op_i       (alu_op),
    .lis_op_i       (lis_op),
    .is_loadstore_i (is_ls),
    .s1_i           (s1),
    .s2_i           (s2),
    .rs2_i          (rs2),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_wb_o       (res_wb),
    .res_err_o      (res_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  typedef struct {
    logic [3:0]  alu_op;
    logic [3:0]  lis_op;
    logic        is_ls;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gnt_dly;
    logic [31:0] exp_data;
    logic        exp_wb;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        wb;
    logic        err;
  } exp_t;

  localparam int NV = 25;
  vec_t vecs [0:NV-1];
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop the oldest expected result on every result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data %h with no expected entry", res_data);
      end else begin
        mon_e = sb_q.pop_front();
        $display("result data=%h wb=%b err=%b (expected %h %b %b)",
                 res_data, res_wb, res_err, mon_e.data, mon_e.wb, mon_e.err);
        chk("res_data", res_data, mon_e.data);
        chk("res_wb", {31'd0, res_wb}, {31'd0, mon_e.wb});
        chk("res_err", {31'd0, res_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    chk($sformatf("v%0d issue_ready", idx), {31'd0, issue_ready}, 32'd1);
    alu_op = v.alu_op; lis_op = v.lis_op; is_ls = v.is_ls;
    s1 = v.s1; s2 = v.s2; rs2 = v.rs2; issue_valid = 1'b1;
    e.data = v.exp_data; e.wb = v.exp_wb; e.err = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs: the unit must work from its registered copies.
    issue_valid = 1'b0;
    alu_op = 4'($urandom); lis_op = 4'($urandom); is_ls = 1'($urandom);
    s1 = $urandom; s2 = $urandom; rs2 = $urandom;
    if (v.is_ls && !v.exp_err) begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d mem_req", idx), {31'd0, mem_req}, 32'd1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
        chk($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
        chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.exp_we});
        if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
        chk($sformatf("v%0d busy", idx), {31'd0, issue_ready}, 32'd0);
        mem_gnt = (k == v.gnt_dly);
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d mem_req_drop", idx), {31'd0, mem_req}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    chk($sformatf("v%0d res_valid", idx), {31'd0, res_valid}, 32'd1);
    chk($sformatf("v%0d mem_req_off", idx), {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL v%0d drained: got %0d pending results expected 0", idx, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    //            alu   lis   ls  s1            s2            rs2           rdata       dly exp_data      wb err addr        be    we wdata
    vecs[0]  = '{4'd0, 4'd0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        0, 32'h80000000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[1]  = '{4'd1, 4'd0, 0, 32'h00000005, 32'h00000007, 32'h0,        32'h0,        0, 32'hFFFFFFFE, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[2]  = '{4'd2, 4'd0, 0, 32'h00000001, 32'h00000023, 32'h0,        32'h0,        0, 32'h00000008, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[3]  = '{4'd3, 4'd0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        0, 32'h00000001, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[4]  = '{4'd4, 4'd0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        0, 32'h00000000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[5]  = '{4'd5, 4'd0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        0, 32'h0FF00FF0, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[6]  = '{4'd6, 4'd0, 0, 32'h80000000, 32'h00000004, 32'h0,        32'h0,        0, 32'h08000000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[7]  = '{4'd7, 4'd0, 0, 32'h80000000, 32'h00000004, 32'h0,        32'h0,        0, 32'hF8000000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[8]  = '{4'd8, 4'd0, 0, 32'h00FF00FF, 32'h0F0F0000, 32'h0,        32'h0,        0, 32'h0FFF00FF, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[9]  = '{4'd9, 4'd0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        0, 32'hF000F000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[10] = '{4'd13,4'd0, 0, 32'h00000005, 32'h00000006, 32'h0,        32'h0,        0, 32'h00000000, 1, 0, 32'h0,      4'h0, 0, 32'h0};
    vecs[11] = '{4'd5, 4'h0, 1, 32'h00001000, 32'h00000003, 32'h0,        32'h80FF0000, 2, 32'hFFFFFF80, 1, 0, 32'h1000,   4'hF, 0, 32'h0};
    vecs[12] = '{4'd0, 4'h4, 1, 32'h00001000, 32'h00000003, 32'h0,        32'h80FF0000, 0, 32'h00000080, 1, 0, 32'h1000,   4'hF, 0, 32'h0};
    vecs[13] = '{4'd0, 4'h1, 1, 32'h00001000, 32'h00000002, 32'h0,        32'h80FF0000, 1, 32'hFFFF80FF, 1, 0, 32'h1000,   4'hF, 0, 32'h0};
    vecs[14] = '{4'd0, 4'h5, 1, 32'h00001000, 32'h00000002, 32'h0,        32'h80FF0000, 0, 32'h000080FF, 1, 0, 32'h1000,   4'hF, 0, 32'h0};
    vecs[15] = '{4'd0, 4'h0, 1, 32'h00001000, 32'h00000001, 32'h0,        32'h00007F00, 0, 32'h0000007F, 1, 0, 32'h1000,   4'hF, 0, 32'h0};
    vecs[16] = '{4'd0, 4'h2, 1, 32'h00001000, 32'h00000004, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 32'h1004,   4'hF, 0, 32'h0};
    vecs[17] = '{4'd0, 4'h9, 1, 32'h00002000, 32'h00000002, 32'h1234ABCD, 32'h55555555, 1, 32'h00000000, 0, 0, 32'h2000,   4'hC, 1, 32'hABCDABCD};
    vecs[18] = '{4'd0, 4'h8, 1, 32'h00002000, 32'h00000001, 32'h000000EF, 32'h55555555, 0, 32'h00000000, 0, 0, 32'h2000,   4'h2, 1, 32'hEFEFEFEF};
    vecs[19] = '{4'd0, 4'hA, 1, 32'h00002000, 32'h00000008, 32'hCAFEF00D, 32'h55555555, 3, 32'h00000000, 0, 0, 32'h2008,   4'hF, 1, 32'hCAFEF00D};
    vecs[20] = '{4'd0, 4'h2, 1, 32'h00001000, 32'h00000001, 32'h0,        32'h0,        0, 32'h00000000, 0, 1, 32'h0,      4'h0, 0, 32'h0};
    vecs[21] = '{4'd0, 4'h1, 1, 32'h00001000, 32'h00000003, 32'h0,        32'h0,        0, 32'h00000000, 0, 1, 32'h0,      4'h0, 0, 32'h0};
    vecs[22] = '{4'd0, 4'h3, 1, 32'h00001000, 32'h00000000, 32'h0,        32'h0,        0, 32'h00000000, 0, 1, 32'h0,      4'h0, 0, 32'h0};
    vecs[23] = '{4'd0, 4'hA, 1, 32'h00002000, 32'h00000002, 32'h11111111, 32'h0,        0, 32'h00000000, 0, 1, 32'h0,      4'h0, 0, 32'h0};
    vecs[24] = '{4'd0, 4'h0, 1, 32'h00001004, 32'hFFFFFFFF, 32'h0,        32'h7F000000, 1, 32'h0000007F, 1, 0, 32'h1000,   4'hF, 0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst res_data", res_data, 32'd0);
    chk("rst res_wb", {31'd0, res_wb}, 32'd0);
    chk("rst res_err", {31'd0, res_err}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Backpressure: result held for 5 cycles, new issue attempts ignored.
    @(negedge clk);
    res_ready = 1'b0;
    alu_op = 4'd5; lis_op = 4'd0; is_ls = 1'b0;
    s1 = 32'h0000FFFF; s2 = 32'h00FF00FF; issue_valid = 1'b1;
    chk("bp issue_ready", {31'd0, issue_ready}, 32'd1);
    mon_e.data = 32'h00FFFF00; mon_e.wb = 1'b1; mon_e.err = 1'b0;
    sb_q.push_back(mon_e);
    @(posedge clk); #1;
    alu_op = 4'd0; s1 = 32'h12345678; s2 = 32'h1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp c%0d res_valid", k), {31'd0, res_valid}, 32'd1);
      chk($sformatf("bp c%0d res_data", k), res_data, 32'h00FFFF00);
      chk($sformatf("bp c%0d res_wb", k), {31'd0, res_wb}, 32'd1);
      chk($sformatf("bp c%0d issue_ready", k), {31'd0, issue_ready}, 32'd0);
    end
    issue_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp idle issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("bp idle res_valid", {31'd0, res_valid}, 32'd0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp drained: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end

    // Reset while waiting for a load response; a late response is ignored.
    alu_op = 4'd0; lis_op = 4'h2; is_ls = 1'b1;
    s1 = 32'h00003000; s2 = 32'h0; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("rw mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rw wait busy", {31'd0, issue_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rw issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rw res_valid", {31'd0, res_valid}, 32'd0);
    chk("rw mem_req", {31'd0, mem_req}, 32'd0);
    chk("rw mem_addr", mem_addr, 32'd0);
    chk("rw mem_be", {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rw stale c%0d res_valid", k), {31'd0, res_valid}, 32'd0);
      chk($sformatf("rw stale c%0d issue_ready", k), {31'd0, issue_ready}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_exec_unit_mc.md
# core_exec_unit_mc

Multi-cycle, parametrised execution unit for the RV32I core, sitting between decode/register-read and writeback. It evaluates ALU operations and performs loads/stores over a request/grant/response data-memory port, so it tolerates variable memory latency. An issue handshake and a result handshake with backpressure let it stall the core. It adds byte/half/word lane steering, load sign/zero extension and misalignment trapping.

## Interface
Parameters:
- XLEN, 32, datapath width (register data, operands, result).
- ADDR_WIDTH, 32, data-memory address width; the address is the low ADDR_WIDTH bits of the ALU sum.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- issue_valid_i  input  1  operation presented.
- issue_ready_o  output  1  unit idle; accepts on valid&&ready.
- alu_op_i  input  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9; other codes give 0.
- lis_op_i  input  4  bit3=store, bit2=unsigned load, bits[1:0] size (0=byte, 1=half, 2=word, 3 illegal → misaligned).
- is_loadstore_i  input  1  memory op; ALU forced to ADD for the address.
- s1_i, s2_i  input  XLEN  operands (s2 = immediate for memory ops).
- rs2_i  input  XLEN  store data.
- res_valid_o  output  1  result available.
- res_ready_i  input  1  writeback accepts.
- res_data_o  output  XLEN  ALU result or extended load data; 0 for stores.
- res_wb_o  output  1  1 for ALU ops and loads, 0 for stores.
- res_err_o  output  1  misaligned access; no memory transaction was issued.
- mem_req_o  output  1  memory request.
- mem_gnt_i  input  1  request accepted this cycle.
- mem_we_o  output  1  write.
- mem_be_o  output  XLEN/8  byte enables.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address (low log2(XLEN/8) bits zero).
- mem_wdata_o  output  XLEN  store data shifted into its lanes.
- mem_rvalid_i  input  1  response/ack, one per granted request.
- mem_rdata_i  input  XLEN  read word.

## Operation
- States: IDLE, REQ, WAIT, RESP. IDLE → (accept, ALU op or misaligned) RESP; IDLE → (accept, aligned memory op) REQ; REQ → (mem_gnt_i) WAIT; WAIT → (mem_rvalid_i) RESP; RESP → (res_ready_i) IDLE.
- All operands and op codes are registered on accept; inputs are ignored afterward.
- ALU: shifts use s2[log2(XLEN)-1:0]; SLT signed, SLTU unsigned; add/sub wrap modulo 2^XLEN.
- Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; size 3 is always misaligned. Misaligned → res_err_o=1, res_wb_o=0, res_data_o=0, no mem_req_o.
- Store lanes: byte → be=1<<addr[1:0], wdata=rs2[7:0] replicated; half → be=0b11<<addr[1:0], wdata=rs2[15:0] replicated; word → be=all ones.
- Load: select the byte/half at addr offset from mem_rdata_i, sign-extend unless bit2 is set; word passes through.
- Stores wait for mem_rvalid_i (write ack) before RESP; rdata is ignored.

## Timing
- Reset values: issue_ready_o=1, res_valid_o=0, res_data_o=0, res_wb_o=0, res_err_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0; state IDLE.
- issue_ready_o=1 only in IDLE: one operation in flight.
- ALU op latency: accept at cycle N, res_valid_o at N+1.
- Memory op: mem_req_o asserted from N+1, held with stable addr/we/be/wdata until the cycle of mem_gnt_i (inclusive), deasserted next cycle. Best case, with gnt at N+1 and rvalid at N+2, res_valid_o is asserted at N+3.
- mem_rvalid_i in the same cycle as mem_gnt_i is not legal (memory latency ≥1).
- RESP holds res_* stable until res_ready_i; the next accept is possible the cycle after the handshake.
- Reset mid-transaction: immediate return to IDLE with mem_req_o=0; any outstanding response is dropped. The memory must be reset together with the unit.
- mem_rvalid_i outside WAIT is ignored.

## Test plan
- ADD s1=0x7FFFFFFF, s2=1, accept at cycle 0 → res_valid_o at 1, res_data_o=0x80000000, res_wb_o=1; SRA 0x80000000 by 4 → 0xF8000000.
- LB s1=0x1000, s2=3, gnt delayed 2 cycles, rdata=0x80FF_0000 → addr=0x1000, be=0xF held during stall, res_data_o=0xFFFFFF80; LBU → 0x00000080.
- SH rs2=0x1234ABCD at address 0x2002 → be=0b1100, wdata=0xABCDABCD, we=1; after rvalid res_wb_o=0, res_data_o=0.
- LW at 0x1001 → res_err_o=1 next cycle, mem_req_o never asserted.
- res_ready_i held low for 5 cycles → res_* stable and issue_ready_o=0 throughout; accepted at 6.
- Assert rst while in WAIT → outputs at reset values within the same cycle; a stale mem_rvalid_i afterward produces no res_valid_o.
